// File: rtl/id_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_pkg
//  Description : Shared decode definitions for the instruction-decode stage.
//                Opcode classes, immediate formats, the per-opcode control
//                record, the illegal default and the XLEN legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_stage_pkg;

  // Major opcode classes (inst[6:0])
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // Immediate layout selector; FMT_R yields a zero immediate
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_e;

  // Control derived from the opcode alone (before the rd=x0 override)
  typedef struct packed {
    logic     rs1_en;
    logic     rs2_en;
    logic     rd_we;
    logic     illegal;
    imm_fmt_e fmt;
  } dec_ctrl_t;

  // Unknown opcodes: flagged, no register traffic, zero immediate
  localparam dec_ctrl_t DEC_ILLEGAL = '{rs1_en: 1'b0, rs2_en: 1'b0, rd_we: 1'b0,
                                        illegal: 1'b1, fmt: FMT_R};

  function automatic logic xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  // Opcode-class decode; the *-32 classes exist only on RV64
  function automatic dec_ctrl_t decode_opcode(input logic [6:0] opc, input logic rv64);
    dec_ctrl_t d;
    d = DEC_ILLEGAL;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
        d = '{rs1_en: 1'b1, rs2_en: 1'b0, rd_we: 1'b1, illegal: 1'b0, fmt: FMT_I};
      OPC_OP_IMM_32:
        if (rv64) d = '{rs1_en: 1'b1, rs2_en: 1'b0, rd_we: 1'b1, illegal: 1'b0, fmt: FMT_I};
      OPC_STORE:
        d = '{rs1_en: 1'b1, rs2_en: 1'b1, rd_we: 1'b0, illegal: 1'b0, fmt: FMT_S};
      OPC_BRANCH:
        d = '{rs1_en: 1'b1, rs2_en: 1'b1, rd_we: 1'b0, illegal: 1'b0, fmt: FMT_B};
      OPC_OP:
        d = '{rs1_en: 1'b1, rs2_en: 1'b1, rd_we: 1'b1, illegal: 1'b0, fmt: FMT_R};
      OPC_OP_32:
        if (rv64) d = '{rs1_en: 1'b1, rs2_en: 1'b1, rd_we: 1'b1, illegal: 1'b0, fmt: FMT_R};
      OPC_LUI, OPC_AUIPC:
        d = '{rs1_en: 1'b0, rs2_en: 1'b0, rd_we: 1'b1, illegal: 1'b0, fmt: FMT_U};
      OPC_JAL:
        d = '{rs1_en: 1'b0, rs2_en: 1'b0, rd_we: 1'b1, illegal: 1'b0, fmt: FMT_J};
      OPC_MISC_MEM:
        d = '{rs1_en: 1'b0, rs2_en: 1'b0, rd_we: 1'b0, illegal: 1'b0, fmt: FMT_I};
      default: d = DEC_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_inst_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : id_inst_fifo
//  Description : Circular instruction buffer carrying {pc, inst}. Push is
//                refused whenever full (a same-cycle pop does not make room);
//                flush empties it and drops any push/pop in that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_inst_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_ready = (r_count < CNT_W'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && o_ready && !i_flush;
  assign w_pop   = i_pop && o_valid && !i_flush;

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, written at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : RISC-V RV32I/RV64I decode stage. Buffers fetched
//                instructions, decodes the buffer head, reads the register
//                file, stalls on load-use hazards and registers the result
//                into a single valid/ready output slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [4:0]      rs1_addr,
  output logic            rs1_en,
  output logic [4:0]      rs2_addr,
  output logic            rs2_en,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            ex_load_valid,
  input  logic [4:0]      ex_load_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd_addr,
  output logic            out_rd_we,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_illegal
);

  localparam int   ENTRY_W = XLEN + 32;
  localparam logic XLEN_OK = xlen_legal(XLEN);
  localparam logic RV64    = (XLEN == 64);

  logic               w_head_valid;
  logic [ENTRY_W-1:0] w_head;
  logic [XLEN-1:0]    w_head_pc;
  logic [31:0]        w_inst;
  dec_ctrl_t          w_ctrl;
  logic               w_rs1_en;
  logic               w_rs2_en;
  logic               w_rd_we;
  logic [XLEN-1:0]    w_imm;
  logic               w_hazard;
  logic               w_xfer;

  logic               r_out_valid;
  logic [XLEN-1:0]    r_out_pc;
  logic [XLEN-1:0]    r_out_rs1_data;
  logic [XLEN-1:0]    r_out_rs2_data;
  logic [XLEN-1:0]    r_out_imm;
  logic [4:0]         r_out_rd_addr;
  logic               r_out_rd_we;
  logic [6:0]         r_out_opcode;
  logic [2:0]         r_out_funct3;
  logic [6:0]         r_out_funct7;
  logic               r_out_illegal;

  id_inst_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (in_valid),
    .o_ready (in_ready),
    .i_data  ({in_pc, in_inst}),
    .i_pop   (w_xfer),
    .o_valid (w_head_valid),
    .o_data  (w_head)
  );

  assign w_head_pc = w_head[ENTRY_W-1:32];
  assign w_inst    = w_head[31:0];

  // Opcode-class decode of the head; an unsupported XLEN decodes everything as illegal
  always_comb begin
    w_ctrl = DEC_ILLEGAL;
    if (XLEN_OK) w_ctrl = decode_opcode(w_inst[6:0], RV64);
  end

  // Read ports are idle while the buffer is empty; disabled ports present x0
  assign w_rs1_en = w_head_valid && w_ctrl.rs1_en;
  assign w_rs2_en = w_head_valid && w_ctrl.rs2_en;
  assign rs1_en   = w_rs1_en;
  assign rs2_en   = w_rs2_en;
  assign rs1_addr = w_rs1_en ? w_inst[19:15] : 5'd0;
  assign rs2_addr = w_rs2_en ? w_inst[24:20] : 5'd0;
  assign w_rd_we  = w_ctrl.rd_we && (w_inst[11:7] != 5'd0);

  // Sign-extended immediate assembly for each instruction format
  always_comb begin
    w_imm = '0;
    case (w_ctrl.fmt)
      FMT_I:   w_imm = {{(XLEN-11){w_inst[31]}}, w_inst[30:20]};
      FMT_S:   w_imm = {{(XLEN-11){w_inst[31]}}, w_inst[30:25], w_inst[11:7]};
      FMT_B:   w_imm = {{(XLEN-12){w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
      FMT_U:   w_imm = {{(XLEN-31){w_inst[31]}}, w_inst[30:12], 12'd0};
      FMT_J:   w_imm = {{(XLEN-20){w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  // A load in execute whose rd feeds an enabled head source must stall the head
  assign w_hazard = ex_load_valid && (ex_load_rd != 5'd0) &&
                    ((w_rs1_en && (ex_load_rd == rs1_addr)) ||
                     (w_rs2_en && (ex_load_rd == rs2_addr)));

  assign w_xfer = w_head_valid && !w_hazard && (!r_out_valid || out_ready);

  // Output slot: load on transfer, empty on consume, flush wins over both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_pc       <= '0;
      r_out_rs1_data <= '0;
      r_out_rs2_data <= '0;
      r_out_imm      <= '0;
      r_out_rd_addr  <= '0;
      r_out_rd_we    <= 1'b0;
      r_out_opcode   <= '0;
      r_out_funct3   <= '0;
      r_out_funct7   <= '0;
      r_out_illegal  <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid    <= 1'b1;
      r_out_pc       <= w_head_pc;
      r_out_rs1_data <= rs1_data;
      r_out_rs2_data <= rs2_data;
      r_out_imm      <= w_imm;
      r_out_rd_addr  <= w_inst[11:7];
      r_out_rd_we    <= w_rd_we;
      r_out_opcode   <= w_inst[6:0];
      r_out_funct3   <= w_inst[14:12];
      r_out_funct7   <= w_inst[31:25];
      r_out_illegal  <= w_ctrl.illegal;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_pc       = r_out_pc;
  assign out_rs1_data = r_out_rs1_data;
  assign out_rs2_data = r_out_rs2_data;
  assign out_imm      = r_out_imm;
  assign out_rd_addr  = r_out_rd_addr;
  assign out_rd_we    = r_out_rd_we;
  assign out_opcode   = r_out_opcode;
  assign out_funct3   = r_out_funct3;
  assign out_funct7   = r_out_funct7;
  assign out_illegal  = r_out_illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_id_stage
//  Description : Scoreboarded bench for id_stage (XLEN=64, DEPTH=2) plus an
//                XLEN=32 instance for the RV64-only opcode checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] imm;
    logic        chk_imm;
    logic        rd_we;
    logic        illegal;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  exp_t sb[$];
  exp_t e;

  // ---------------- XLEN=64 instance ----------------
  logic        rst_n, flush, in_valid, in_ready, ex_load_valid, out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic [4:0]  rs1_addr, rs2_addr, ex_load_rd, out_rd_addr;
  logic        rs1_en, rs2_en, out_valid, out_rd_we, out_illegal;
  logic [63:0] rs1_data, rs2_data, out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;

  // ---------------- XLEN=32 instance ----------------
  logic        in_valid_32, in_ready_32, out_valid_32, out_rd_we_32, out_illegal_32;
  logic [31:0] in_pc_32, in_inst_32, rs1_data_32, rs2_data_32;
  logic [31:0] out_pc_32, out_rs1_data_32, out_rs2_data_32, out_imm_32;
  logic [4:0]  rs1_addr_32, rs2_addr_32, out_rd_addr_32;
  logic        rs1_en_32, rs2_en_32;
  logic [6:0]  out_opcode_32, out_funct7_32;
  logic [2:0]  out_funct3_32;

  function automatic logic [63:0] regval(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    return ({59'd0, a} * 64'h0101_0101_0101_0101) ^ 64'hA5A5_0000_0000_5A5A;
  endfunction

  function automatic logic [31:0] regval32(input logic [4:0] a);
    logic [63:0] v;
    v = regval(a);
    return v[31:0];
  endfunction

  assign rs1_data    = regval(rs1_addr);
  assign rs2_data    = regval(rs2_addr);
  assign rs1_data_32 = regval32(rs1_addr_32);
  assign rs2_data_32 = regval32(rs2_addr_32);

  id_stage #(.XLEN(64), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rs1_addr(rs1_addr), .rs1_en(rs1_en), .rs2_addr(rs2_addr), .rs2_en(rs2_en),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_illegal(out_illegal)
  );

  id_stage #(.XLEN(32), .DEPTH(2)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid_32), .in_ready(in_ready_32), .in_pc(in_pc_32), .in_inst(in_inst_32),
    .rs1_addr(rs1_addr_32), .rs1_en(rs1_en_32), .rs2_addr(rs2_addr_32), .rs2_en(rs2_en_32),
    .rs1_data(rs1_data_32), .rs2_data(rs2_data_32),
    .ex_load_valid(1'b0), .ex_load_rd(5'd0),
    .out_valid(out_valid_32), .out_ready(1'b1), .out_pc(out_pc_32),
    .out_rs1_data(out_rs1_data_32), .out_rs2_data(out_rs2_data_32), .out_imm(out_imm_32),
    .out_rd_addr(out_rd_addr_32), .out_rd_we(out_rd_we_32), .out_opcode(out_opcode_32),
    .out_funct3(out_funct3_32), .out_funct7(out_funct7_32), .out_illegal(out_illegal_32)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every consumed output is compared against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: output pc=%h inst_op=%h appeared, required no output", out_pc, out_opcode);
      end else begin
        e = sb.pop_front();
        if (out_pc !== e.pc || out_opcode !== e.inst[6:0] || out_funct3 !== e.inst[14:12] ||
            out_funct7 !== e.inst[31:25] || out_rd_addr !== e.inst[11:7] ||
            out_rd_we !== e.rd_we || out_illegal !== e.illegal ||
            (e.chk_imm && out_imm !== e.imm) ||
            out_rs1_data !== regval(e.rs1) || out_rs2_data !== regval(e.rs2)) begin
          n_errors++;
          $display("FAIL sb_output: got pc=%h op=%h f3=%h f7=%h rd=%0d we=%b ill=%b imm=%h rs1d=%h rs2d=%h; required pc=%h inst=%h we=%b ill=%b imm=%h rs1d=%h rs2d=%h",
                   out_pc, out_opcode, out_funct3, out_funct7, out_rd_addr, out_rd_we, out_illegal,
                   out_imm, out_rs1_data, out_rs2_data, e.pc, e.inst, e.rd_we, e.illegal, e.imm,
                   regval(e.rs1), regval(e.rs2));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] imm,
                              input logic chk, input logic we, input logic ill,
                              input logic [4:0] r1, input logic [4:0] r2);
    exp_t x;
    x.pc = pc; x.inst = inst; x.imm = imm; x.chk_imm = chk;
    x.rd_we = we; x.illegal = ill; x.rs1 = r1; x.rs2 = r2;
    return x;
  endfunction

  // Present one instruction until accepted, then record its expected result
  task automatic send(input exp_t x);
    logic acc;
    int   n;
    in_valid = 1'b1; in_pc = x.pc; in_inst = x.inst;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin
      acc = in_ready;
      tick();
      n++;
    end
    n_checks++;
    if (!acc) begin
      n_errors++;
      $display("FAIL send_accept: inst %h not accepted in 20 cycles, required acceptance", x.inst);
    end else begin
      sb.push_back(x);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    ex_load_valid = 1'b0; ex_load_rd = '0; out_ready = 1'b1;
    in_valid_32 = 1'b0; in_pc_32 = '0; in_inst_32 = '0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'd0 || out_imm !== 64'd0 || out_illegal !== 1'b0 || out_rd_we !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%b pc=%h imm=%h ill=%b we=%b, required all 0",
               out_valid, out_pc, out_imm, out_illegal, out_rd_we);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || rs1_en !== 1'b0 || rs2_en !== 1'b0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: in_ready=%b rs1_en=%b rs2_en=%b out_valid=%b, required 1/0/0/0",
               in_ready, rs1_en, rs2_en, out_valid);
    end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    send(mk(64'h8000_0000, 32'h0050_0093, 64'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0));
    n_checks++;
    if (out_valid !== 1'b0 || rs1_en !== 1'b1 || rs1_addr !== 5'd0 || rs2_en !== 1'b0) begin
      n_errors++;
      $display("FAIL addi_head: out_valid=%b rs1_en=%b rs1_addr=%0d rs2_en=%b, required 0/1/0/0",
               out_valid, rs1_en, rs1_addr, rs2_en);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_imm !== 64'd5 || out_rd_addr !== 5'd1 || out_rd_we !== 1'b1) begin
      n_errors++;
      $display("FAIL addi_out: valid=%b imm=%h rd=%0d we=%b, required 1/5/1/1",
               out_valid, out_imm, out_rd_addr, out_rd_we);
    end
    tick();
  endtask

  task automatic test_lui();
    out_ready = 1'b1;
    send(mk(64'h100, 32'h1234_5137, 64'h0000_0000_1234_5000, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0));
    send(mk(64'h104, 32'h8000_01B7, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0));
    n_checks++;
    if (out_valid !== 1'b1 || out_imm !== 64'h0000_0000_1234_5000 || out_rd_addr !== 5'd2) begin
      n_errors++;
      $display("FAIL lui_pos: valid=%b imm=%h rd=%0d, required 1/0000000012345000/2",
               out_valid, out_imm, out_rd_addr);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_imm !== 64'hFFFF_FFFF_8000_0000) begin
      n_errors++;
      $display("FAIL lui_neg: valid=%b imm=%h, required 1/ffffffff80000000", out_valid, out_imm);
    end
    tick();
  endtask

  task automatic test_formats();
    exp_t t[$];
    int   c0;
    out_ready = 1'b1;
    t.push_back(mk(64'h1000, 32'h0011_2423, 64'd8,                  1'b1, 1'b0, 1'b0, 5'd2, 5'd1)); // sw
    t.push_back(mk(64'h1004, 32'hFE20_8EE3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2)); // beq -4
    t.push_back(mk(64'h1008, 32'h0080_00EF, 64'd8,                  1'b1, 1'b1, 1'b0, 5'd0, 5'd0)); // jal
    t.push_back(mk(64'h100C, 32'h0000_1197, 64'h1000,               1'b1, 1'b1, 1'b0, 5'd0, 5'd0)); // auipc
    t.push_back(mk(64'h1010, 32'h0010_009B, 64'd1,                  1'b1, 1'b1, 1'b0, 5'd0, 5'd0)); // addiw
    t.push_back(mk(64'h1014, 32'h0000_007F, 64'd0,                  1'b1, 1'b0, 1'b1, 5'd0, 5'd0)); // illegal
    t.push_back(mk(64'h1018, 32'h0FF0_000F, 64'd0,                  1'b0, 1'b0, 1'b0, 5'd0, 5'd0)); // fence
    t.push_back(mk(64'h101C, 32'h0020_8033, 64'd0,                  1'b1, 1'b0, 1'b0, 5'd1, 5'd2)); // add x0
    t.push_back(mk(64'h1020, 32'hFFC1_2083, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0)); // lw -4
    t.push_back(mk(64'h1024, 32'h0073_02BB, 64'd0,                  1'b1, 1'b1, 1'b0, 5'd6, 5'd7)); // addw
    t.push_back(mk(64'h1028, 32'h0002_80E7, 64'd0,                  1'b1, 1'b1, 1'b0, 5'd5, 5'd0)); // jalr
    t.push_back(mk(64'h102C, 32'h0000_0073, 64'd0,                  1'b1, 1'b0, 1'b0, 5'd0, 5'd0)); // ecall
    c0 = cyc;
    foreach (t[i]) send(t[i]);
    n_checks++;
    if (cyc - c0 != t.size()) begin
      n_errors++;
      $display("FAIL throughput: %0d cycles for %0d instructions, required %0d", cyc - c0, t.size(), t.size());
    end
    repeat (3) tick();
  endtask

  task automatic test_hazard();
    out_ready = 1'b1; ex_load_valid = 1'b1; ex_load_rd = 5'd3;
    send(mk(64'h2000, 32'h0051_8233, 64'd0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd5));
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || rs1_addr !== 5'd3 || rs2_addr !== 5'd5) begin
        n_errors++;
        $display("FAIL hazard_hold[%0d]: out_valid=%b rs1=%0d rs2=%0d, required 0/3/5", i, out_valid, rs1_addr, rs2_addr);
      end
    end
    ex_load_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_rs1_data !== regval(5'd3) || out_rs2_data !== regval(5'd5)) begin
      n_errors++;
      $display("FAIL hazard_release: valid=%b rs1d=%h rs2d=%h, required 1/%h/%h",
               out_valid, out_rs1_data, out_rs2_data, regval(5'd3), regval(5'd5));
    end
    tick();
    // rs2 match stalls; an unrelated load destination does not
    ex_load_valid = 1'b1; ex_load_rd = 5'd5;
    send(mk(64'h2004, 32'h0051_8233, 64'd0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd5));
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL hazard_rs2: out_valid=%b, required 0", out_valid);
    end
    ex_load_rd = 5'd6;
    tick();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL hazard_unrelated: out_valid=%b, required 1", out_valid);
    end
    ex_load_valid = 1'b0; ex_load_rd = 5'd0;
    tick();
  endtask

  task automatic test_backpressure();
    exp_t b3;
    logic a, acc4;
    out_ready = 1'b0;
    send(mk(64'h3000, 32'h0010_0093, 64'd1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0));
    send(mk(64'h3004, 32'h0020_0113, 64'd2, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0));
    send(mk(64'h3008, 32'h0030_0193, 64'd3, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0));
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_full: in_ready=%b out_valid=%b, required 0/1", in_ready, out_valid);
    end
    b3 = mk(64'h300C, 32'h0040_0213, 64'd4, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
    in_valid = 1'b1; in_pc = b3.pc; in_inst = b3.inst;
    repeat (2) begin
      tick();
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold: in_ready=%b, required 0", in_ready);
      end
    end
    out_ready = 1'b1; acc4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL bp_stream[%0d]: out_valid=%b, required 1", i, out_valid);
      end
      a = in_valid && in_ready;
      tick();
      if (a) begin sb.push_back(b3); in_valid = 1'b0; acc4 = 1'b1; end
    end
    in_valid = 1'b0;
    n_checks++;
    if (!acc4 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_drain: fourth accepted=%b out_valid=%b, required 1/0", acc4, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(mk(64'h4000, 32'h0010_0093, 64'd1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0));
    send(mk(64'h4004, 32'h0020_0113, 64'd2, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0));
    send(mk(64'h4008, 32'h0030_0193, 64'd3, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0));
    flush = 1'b1; in_valid = 1'b1; in_pc = 64'h400C; in_inst = 32'h0040_0213;
    sb.delete();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || rs1_en !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_state: out_valid=%b in_ready=%b rs1_en=%b, required 0/1/0", out_valid, in_ready, rs1_en);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_quiet[%0d]: out_valid=%b, required 0", i, out_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(mk(64'h5000, 32'h0010_0093, 64'd1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0));
    send(mk(64'h5004, 32'h0020_0113, 64'd2, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0));
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || rs1_en !== 1'b0 || out_pc !== 64'd0) begin
      n_errors++;
      $display("FAIL async_reset: out_valid=%b in_ready=%b rs1_en=%b out_pc=%h, required 0/1/0/0",
               out_valid, in_ready, rs1_en, out_pc);
    end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset_after: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_xlen32();
    in_valid_32 = 1'b1; in_pc_32 = 32'h100; in_inst_32 = 32'h0010_009B;
    tick();
    in_valid_32 = 1'b0;
    n_checks++;
    if (rs1_en_32 !== 1'b0 || rs2_en_32 !== 1'b0) begin
      n_errors++;
      $display("FAIL x32_addiw_head: rs1_en=%b rs2_en=%b, required 0/0", rs1_en_32, rs2_en_32);
    end
    tick();
    n_checks++;
    if (out_valid_32 !== 1'b1 || out_illegal_32 !== 1'b1 || out_rd_we_32 !== 1'b0) begin
      n_errors++;
      $display("FAIL x32_addiw_out: valid=%b ill=%b we=%b, required 1/1/0", out_valid_32, out_illegal_32, out_rd_we_32);
    end
    in_valid_32 = 1'b1; in_pc_32 = 32'h104; in_inst_32 = 32'hFFF0_0093;
    tick();
    in_valid_32 = 1'b1; in_pc_32 = 32'h108; in_inst_32 = 32'h8000_01B7;
    tick();
    in_valid_32 = 1'b0;
    n_checks++;
    if (out_valid_32 !== 1'b1 || out_imm_32 !== 32'hFFFF_FFFF || out_illegal_32 !== 1'b0 || out_rd_we_32 !== 1'b1) begin
      n_errors++;
      $display("FAIL x32_addi_neg: valid=%b imm=%h ill=%b we=%b, required 1/ffffffff/0/1",
               out_valid_32, out_imm_32, out_illegal_32, out_rd_we_32);
    end
    tick();
    n_checks++;
    if (out_valid_32 !== 1'b1 || out_imm_32 !== 32'h8000_0000 || out_pc_32 !== 32'h108) begin
      n_errors++;
      $display("FAIL x32_lui: valid=%b imm=%h pc=%h, required 1/80000000/00000108", out_valid_32, out_imm_32, out_pc_32);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lui();
    test_xlen32();
    test_formats();
    test_hazard();
    test_backpressure();
    test_flush();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: %0d expected outputs never appeared, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Parametrised, pipelined RISC-V instruction-decode stage between fetch and execute. It accepts fetched instructions into a `DEPTH`-entry instruction buffer and decodes the head entry for RV32I or RV64I according to `XLEN`. It reads the register file at the head and holds load-use hazards there. Results are registered into a single output slot under a valid/ready handshake, with illegal-opcode flagging and a flush.

## Interface
- `XLEN`, 64 — datapath width; legal values are 32 and 64. The RV64-only opcodes `0011011` and `0111011` decode as illegal when `XLEN`=32.
- `DEPTH`, 2 — instruction buffer entries; a power of two, at least 2.
- `clk` in 1 — the single clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `flush` in 1 — discard everything held in the stage.
- `in_valid` in 1, `in_ready` out 1 — fetch handshake.
- `in_pc` in XLEN, `in_inst` in 32 — fetched PC and instruction word.
- `rs1_addr` out 5, `rs1_en` out 1, `rs2_addr` out 5, `rs2_en` out 1 — register-file read request for the buffer head.
- `rs1_data` in XLEN, `rs2_data` in XLEN — combinational register-file read data.
- `ex_load_valid` in 1, `ex_load_rd` in 5 — execute stage holds a load writing `ex_load_rd`.
- `out_valid` out 1, `out_ready` in 1 — execute handshake.
- `out_pc` out XLEN, `out_rs1_data` out XLEN, `out_rs2_data` out XLEN, `out_imm` out XLEN — registered operands and immediate.
- `out_rd_addr` out 5, `out_rd_we` out 1 — registered destination.
- `out_opcode` out 7, `out_funct3` out 3, `out_funct7` out 7 — registered instruction fields.
- `out_illegal` out 1 — registered illegal-opcode flag.

## Operation
- **Buffer:** circular FIFO with a count of width clog2(DEPTH)+1.
  - `in_ready` = count < DEPTH.
  - Enqueue on `in_valid & in_ready`.
  - When the buffer is full, no enqueue happens, even in a cycle where a dequeue occurs.
- **Head decode (combinational):**

  | Opcode class | rs1_en | rs2_en | rd_we |
  |---|---|---|---|
  | LOAD, OP-IMM, JALR, SYSTEM, OP-IMM-32 | 1 | 0 | 1 |
  | STORE, BRANCH | 1 | 1 | 0 |
  | OP, OP-32 | 1 | 1 | 1 |
  | LUI, AUIPC, JAL | 0 | 0 | 1 |
  | FENCE | 0 | 0 | 0 |
  | Any other opcode | 0 | 0 | 0 |

  - Any opcode outside the table sets `illegal`=1 and forces all enables to 0.
  - A disabled register address reads as 0.
  - `rd_we` is forced to 0 when rd=x0.
- **Immediates:** sign-extended to XLEN.
  - I, S and B forms extend from inst[31]; B has bit0 = 0.
  - U form is inst[31:12]<<12, then sign-extended from bit 31.
  - J form has bit0 = 0.
  - R-type immediate is 0.
- **Hazard:** asserted when `ex_load_valid`, `ex_load_rd`≠0, and `ex_load_rd` equals an enabled head rs address.
- **Transfer:** buffer head moves to the output slot when the buffer is non-empty, there is no hazard, and (`!out_valid` | `out_ready`).
  - `out_rs*_data` capture `rs*_data` at that edge.
- **Output slot:** `out_valid` clears on `out_valid & out_ready` when there is no transfer in the same cycle.
- **Flush:**
  - On the next edge, count, pointers and `out_valid` go to 0.
  - An enqueue or transfer in the flush cycle is dropped.
  - Flush has priority over every other event.
- **Reset:** all outputs and state go to 0; `in_ready` is 1 once reset is released.

## Timing
- Instruction accepted at edge k; `out_valid` is high after edge k+1 at the earliest.
- Sustained throughput is 1 instruction per cycle when `out_ready`=1 and there is no hazard.
- A hazard holds the head for as long as it persists; transfer occurs on the first edge after the hazard clears.
- `rs*_addr` and `rs*_en` are combinational from the head. The register file returns data in the same cycle.
- Stage capacity is DEPTH+1 instructions (DEPTH buffer entries plus the output slot).
- Pointers wrap modulo DEPTH.
- Asynchronous reset mid-operation clears all state immediately.

## Structure
- The opcode constants (7-bit, one per class), the illegal default and the XLEN legality check go in the shared defines header.
- One sub-module: `id_inst_fifo`, parametrised by width and DEPTH, carrying {pc, inst}.
- Decode logic and the output register stay in `id_stage`.

## Test plan
- **ADDI, XLEN=64:** `in_inst`=0x00500093, `in_pc`=0x80000000, `out_ready`=1. Expect:
  - `out_imm`=5, `out_rd_addr`=1, `out_rd_we`=1, `rs1_en`=1, `rs1_addr`=0.
  - `out_valid` high 2 edges after `in_valid`.
- **LUI, XLEN=64:**
  - 0x12345137 → `out_imm`=0x0000000012345000, `out_rd_addr`=2.
  - 0x800001B7 → `out_imm`=0xFFFFFFFF80000000.
- **ADDIW at XLEN=32:** 0x0010009B → `out_illegal`=1, `out_rd_we`=0, `rs1_en`=0.
- **Load-use hazard:** `ex_load_valid`=1, `ex_load_rd`=3, head 0x00518233 (add x4,x3,x5). Expect `out_valid` to stay 0 for 3 cycles. Deassert `ex_load_valid` → `out_valid`=1 on the next edge with `out_rs1_data` = `rs1_data`.
- **Backpressure, DEPTH=2:** `out_ready`=0, stream 4 instructions. Expect:
  - 3 accepted, then `in_ready`=0.
  - After `out_ready`=1, outputs appear in order, one per cycle.
- **Flush:** with 2 instructions buffered and `out_valid`=1, assert `flush` together with `in_valid`. Next cycle expect `out_valid`=0, `in_ready`=1, and no instruction emerges afterwards.
